// File: rtl/r4_seq_ctrl.sv
// Radix-4 butterfly frame sequencer: holds one 4-point frame on the butterfly and steps c1/c2/c3 through four codes.
// Output valid 1+4*SETTLE cycles after acceptance. in_ready only in IDLE, and results hold until out_ready.
module r4_seq_ctrl #(
  parameter logic [2:0]  SEQ0   = 3'b011,
  parameter logic [2:0]  SEQ1   = 3'b110,
  parameter logic [2:0]  SEQ2   = 3'b001,
  parameter logic [2:0]  SEQ3   = 3'b100,
  parameter int unsigned SETTLE = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_xr,
  input  logic [15:0] in_xi,
  output logic [3:0]  bf_xr0,
  output logic [3:0]  bf_xr1,
  output logic [3:0]  bf_xr2,
  output logic [3:0]  bf_xr3,
  output logic [3:0]  bf_xi0,
  output logic [3:0]  bf_xi1,
  output logic [3:0]  bf_xi2,
  output logic [3:0]  bf_xi3,
  output logic        bf_c1,
  output logic        bf_c2,
  output logic        bf_c3,
  input  logic [3:0]  bf_xro,
  input  logic [3:0]  bf_xio,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_xr,
  output logic [15:0] out_xi,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_t      r_state;
  logic        r_first;
  logic [1:0]  r_step;
  logic [2:0]  r_settle;
  logic [15:0] r_hold_xr;
  logic [15:0] r_hold_xi;
  logic [15:0] r_res_xr;
  logic [15:0] r_res_xi;
  logic [2:0]  r_c;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic [7:0]  r_frame_cnt;

  logic        w_settle_done;
  logic [1:0]  w_step_nxt;

  function automatic logic [2:0] seq_of(input logic [1:0] s);
    case (s)
      2'd0:    seq_of = SEQ0;
      2'd1:    seq_of = SEQ1;
      2'd2:    seq_of = SEQ2;
      default: seq_of = SEQ3;
    endcase
  endfunction

  assign w_settle_done = (r_settle == SETTLE_LAST);
  assign w_step_nxt    = r_step + 2'd1;

  // The first RUN cycle only loads the step-0 code, so every code is held SETTLE cycles before its capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b0;
      r_step      <= 2'd0;
      r_settle    <= 3'd0;
      r_hold_xr   <= 16'h0;
      r_hold_xi   <= 16'h0;
      r_res_xr    <= 16'h0;
      r_res_xi    <= 16'h0;
      r_c         <= 3'b000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_hold_xr  <= in_xr;
            r_hold_xi  <= in_xi;
            r_step     <= 2'd0;
            r_settle   <= 3'd0;
            r_first    <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_first) begin
            r_first <= 1'b0;
            r_c     <= seq_of(r_step);
          end else if (w_settle_done) begin
            r_res_xr[{r_step, 2'b00} +: 4] <= bf_xro;
            r_res_xi[{r_step, 2'b00} +: 4] <= bf_xio;
            r_settle <= 3'd0;
            if (r_step == 2'd3) begin
              r_c         <= 3'b000;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_step <= w_step_nxt;
              r_c    <= seq_of(w_step_nxt);
            end
          end else begin
            r_settle <= r_settle + 3'd1;
          end
        end
        S_DONE: begin
          // in_ready is still low here, so a same-cycle in_valid waits for IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_c         <= 3'b000;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign out_xr    = r_res_xr;
  assign out_xi    = r_res_xi;

  assign bf_c1 = r_c[2];
  assign bf_c2 = r_c[1];
  assign bf_c3 = r_c[0];

  assign bf_xr0 = r_hold_xr[3:0];
  assign bf_xr1 = r_hold_xr[7:4];
  assign bf_xr2 = r_hold_xr[11:8];
  assign bf_xr3 = r_hold_xr[15:12];
  assign bf_xi0 = r_hold_xi[3:0];
  assign bf_xi1 = r_hold_xi[7:4];
  assign bf_xi2 = r_hold_xi[11:8];
  assign bf_xi3 = r_hold_xi[15:12];

endmodule

// File: tb/tb_r4_seq_ctrl.sv
// Directed bench for r4_seq_ctrl: a tagged stub or a 4-point DFT stands in for the butterfly.
// A second instance runs with SETTLE=3.
module tb_r4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bf_mode;
  logic [15:0] in_xr, in_xi;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] out_xr, out_xi;
  logic [7:0]  frame_cnt;
  logic [3:0]  bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3;
  logic        bf_c1, bf_c2, bf_c3;
  logic [3:0]  bf_xro, bf_xio;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [15:0] out_xr_b, out_xi_b;
  logic [7:0]  frame_cnt_b;
  logic [3:0]  bxr0, bxr1, bxr2, bxr3, bxi0, bxi1, bxi2, bxi3;
  logic        bc1, bc2, bc3;
  logic [3:0]  bxro, bxio;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  r4_seq_ctrl u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_xr(in_xr), .in_xi(in_xi),
    .bf_xr0(bf_xr0), .bf_xr1(bf_xr1), .bf_xr2(bf_xr2), .bf_xr3(bf_xr3),
    .bf_xi0(bf_xi0), .bf_xi1(bf_xi1), .bf_xi2(bf_xi2), .bf_xi3(bf_xi3),
    .bf_c1(bf_c1), .bf_c2(bf_c2), .bf_c3(bf_c3), .bf_xro(bf_xro), .bf_xio(bf_xio),
    .out_valid(out_valid), .out_ready(out_ready), .out_xr(out_xr), .out_xi(out_xi),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  r4_seq_ctrl #(.SETTLE(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_xr(in_xr), .in_xi(in_xi),
    .bf_xr0(bxr0), .bf_xr1(bxr1), .bf_xr2(bxr2), .bf_xr3(bxr3),
    .bf_xi0(bxi0), .bf_xi1(bxi1), .bf_xi2(bxi2), .bf_xi3(bxi3),
    .bf_c1(bc1), .bf_c2(bc2), .bf_c3(bc3), .bf_xro(bxro), .bf_xio(bxio),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_xr(out_xr_b), .out_xi(out_xi_b),
    .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  // Stub: result = bin index + 8 and its complement. DFT: X[k] = sum x[n]*(-j)^(n*k), mod 16.
  function automatic logic [7:0] bf_model(input logic mode, input logic [2:0] c,
                                          input logic [15:0] xr, input logic [15:0] xi);
    int k;
    logic [3:0] sr, si, r, i, v;
    case (c)
      3'b011:  k = 0;
      3'b110:  k = 1;
      3'b001:  k = 2;
      3'b100:  k = 3;
      default: k = -1;
    endcase
    sr = 4'h0;
    si = 4'h0;
    if (k < 0) return 8'h00;
    if (!mode) begin
      v = 4'(k + 8);
      return {v, ~v};
    end
    for (int n = 0; n < 4; n++) begin
      r = xr[4*n +: 4];
      i = xi[4*n +: 4];
      case ((n * k) % 4)
        0:       begin sr = sr + r; si = si + i; end
        1:       begin sr = sr + i; si = si - r; end
        2:       begin sr = sr - r; si = si - i; end
        default: begin sr = sr - i; si = si + r; end
      endcase
    end
    return {sr, si};
  endfunction

  always_comb begin
    {bf_xro, bf_xio} = bf_model(bf_mode, {bf_c1, bf_c2, bf_c3},
                                {bf_xr3, bf_xr2, bf_xr1, bf_xr0}, {bf_xi3, bf_xi2, bf_xi1, bf_xi0});
    {bxro, bxio} = bf_model(bf_mode, {bc1, bc2, bc3},
                            {bxr3, bxr2, bxr1, bxr0}, {bxi3, bxi2, bxi1, bxi0});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] xr, input logic [15:0] xi);
    in_xr    = xr;
    in_xi    = xi;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 60; i++) begin
      if (out_valid) break;
      step();
    end
    chk("wait_out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [15:0] xr, input logic [15:0] xi,
                          input logic [15:0] exp_r, input logic [15:0] exp_i);
    start_frame(xr, xi);
    wait_out();
    chk({tag, "_xr"}, 32'(out_xr), 32'(exp_r));
    chk({tag, "_xi"}, 32'(out_xi), 32'(exp_i));
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0] seq [4];
    int got_frames, bad_frames;
    seq[0] = 3'b011; seq[1] = 3'b110; seq[2] = 3'b001; seq[3] = 3'b100;
    rst = 1'b1; bf_mode = 1'b0; in_xr = 16'h0; in_xi = 16'h0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("rst_bf_c",      32'({bf_c1, bf_c2, bf_c3}), 32'(0));
    chk("rst_out_xr",    32'(out_xr),    32'(0));

    // Tagged stub: code sequence and slot packing
    start_frame(16'h1234, 16'hABCD);
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_in_ready", 32'(in_ready), 32'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t1_bf_c%0d", k), 32'({bf_c1, bf_c2, bf_c3}), 32'(seq[k]));
    end
    step();
    chk("t1_out_valid", 32'(out_valid), 32'(1));
    chk("t1_out_xr", 32'(out_xr), 32'(16'hBA98));
    chk("t1_out_xi", 32'(out_xi), 32'(16'h4567));
    chk("t1_bf_c_done", 32'({bf_c1, bf_c2, bf_c3}), 32'(0));
    handshake();
    chk("t1_frame_cnt", 32'(frame_cnt), 32'(1));
    chk("t1_out_valid_lo", 32'(out_valid), 32'(0));
    chk("t1_hold_xr", 32'({bf_xr3, bf_xr2, bf_xr1, bf_xr0}), 32'(16'h1234));

    // DFT butterfly model
    bf_mode = 1'b1;
    do_frame("t2_dc", 16'h1111, 16'h0000, 16'h0004, 16'h0000);
    do_frame("t2_ramp", 16'h4321, 16'h0000, 16'hEEEA, 16'hE020);
    bf_mode = 1'b0;

    // Output stall with in_valid held high
    in_xr = 16'h5555; in_xi = 16'h2222; in_valid = 1'b1;
    step();
    wait_out();
    for (int i = 0; i < 20; i++) begin
      chk("t3_stall_xr", 32'(out_xr), 32'(16'hBA98));
      chk("t3_stall_in_ready", 32'(in_ready), 32'(0));
      chk("t3_stall_cnt", 32'(frame_cnt), 32'(3));
      step();
    end
    chk("t3_stall_valid", 32'(out_valid), 32'(1));
    handshake();
    chk("t3_rel_cnt", 32'(frame_cnt), 32'(4));
    chk("t3_rel_in_ready", 32'(in_ready), 32'(1));
    chk("t3_rel_out_valid", 32'(out_valid), 32'(0));
    step();
    chk("t3_next_busy", 32'(busy), 32'(1));
    in_valid = 1'b0;
    wait_out();
    handshake();
    chk("t3_cnt5", 32'(frame_cnt), 32'(5));

    // Reset during step 2
    start_frame(16'h7777, 16'h1111);
    step(); step(); step();
    chk("t4_step2_c", 32'({bf_c1, bf_c2, bf_c3}), 32'(3'b001));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_in_ready", 32'(in_ready), 32'(1));
    chk("t4_out_valid", 32'(out_valid), 32'(0));
    chk("t4_bf_c", 32'({bf_c1, bf_c2, bf_c3}), 32'(0));
    chk("t4_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("t4_busy", 32'(busy), 32'(0));

    // SETTLE=3 instance
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i <= 12) chk($sformatf("t5_c_cyc%0d", i), 32'({bc1, bc2, bc3}), 32'(seq[(i - 1) / 3]));
      if (i == 12) chk("t5_ov_early", 32'(out_valid_b), 32'(0));
      if (i == 13) chk("t5_ov_13", 32'(out_valid_b), 32'(1));
    end
    chk("t5_out_xr", 32'(out_xr_b), 32'(16'hBA98));
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    chk("t5_frame_cnt", 32'(frame_cnt_b), 32'(1));

    // 256 back-to-back frames
    got_frames = 0; bad_frames = 0;
    in_xr = 16'h0F0F; in_xi = 16'hF0F0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3000 && got_frames < 256; i++) begin
      step();
      if (out_valid) begin
        got_frames++;
        if (out_xr !== 16'hBA98 || out_xi !== 16'h4567) bad_frames++;
        if (got_frames == 256) in_valid = 1'b0;
      end
    end
    step();
    out_ready = 1'b0;
    chk("t6_frames", 32'(got_frames), 32'(256));
    chk("t6_bad_frames", 32'(bad_frames), 32'(0));
    chk("t6_frame_cnt_wrap", 32'(frame_cnt), 32'(0));
    chk("t6_idle", 32'(in_ready), 32'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
